pll_lock_sequencer: RTL

//  Sequences the video-clock PLL: pulses its reset, waits for lock, qualifies it as stable,
//  and raises a reset request for the 21.477272 MHz domain until lock is qualified.

---
 rtl/pll_lock_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Sequences the video-clock PLL from the free-running 50 MHz refclk. The
// sequencer pulses the PLL reset, waits for lock and qualifies it as stable.
// Until lock is qualified, it holds a reset request towards the 21.477272 MHz
// video domain. A failed lock attempt is retried after a timeout. Loss of lock
// in RUN starts a new sequence. When the retries run out, the sequencer
// latches a fault.
//
// Optional feature (compile-time macro):
//   PLL_SEQ_LOSS_CNT_EN  defined   -> loss_count counts lock-loss events in RUN
//                        undefined -> loss_count is tied to 0 (no counter)
//
// Ports:
//   refclk      in   1      free-running 50 MHz clock, sole clock
//   rst         in   1      asynchronous active-high reset
//   locked      in   1      PLL lock, asynchronous to refclk
//   restart     in   1      1-cycle pulse: new sequence, clears fault/retries
//   pll_rst     out  1      PLL reset
//   sys_rst_req out  1      hold the video domain in reset
//   ready       out  1      lock qualified (RUN)
//   fail        out  1      retries exhausted (FAIL)
//   retries     out  2      failed attempts this sequence, saturates at 3
//   loss_count  out  CNT_W  lock-loss events seen in RUN, saturating
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 50,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             sys_rst_req,
    output logic             ready,
    output logic             fail,
    output logic [1:0]       retries,
    output logic [CNT_W-1:0] loss_count
);

    // One timer serves both the reset pulse and the lock timeout, so it has
    // to hold the larger of the two terminal counts.
    localparam int TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
    // The internal attempt counter is wide enough for MAX_RETRIES. The
    // retries port is only a saturated view of it.
    localparam int RC_W    = $clog2(MAX_RETRIES + 2);

    typedef enum logic [2:0] {
        S_PRST,
        S_WLOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [STAB_W-1:0] stab;
    logic [RC_W-1:0]   retry_cnt;
    logic              lk_meta;
    logic              lk;

    logic rst_done;
    logic tmr_expired;
    logic qualify;

    // Two-flop synchroniser for the asynchronous lock indicator.
    // NOTE: every flop, the synchroniser included, gets an async reset value.
    // This way no stale lock state survives rst.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments. Each flop then
            // sees the value from before the edge, whatever the statement order.
            lk_meta <= locked;
            lk      <= lk_meta;
        end
    end

    assign rst_done    = (tmr == TMR_W'(RST_CYCLES - 1));
    assign tmr_expired = (tmr == TMR_W'(LOCK_TIMEOUT - 1));
    // stab is 0 in WLOCK. So the first locked cycle there counts as stab=1,
    // and STABLE_CYCLES=1 qualifies straight from WLOCK.
    assign qualify     = lk && (stab == STAB_W'(STABLE_CYCLES - 1));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= S_PRST;
            tmr         <= '0;
            stab        <= '0;
            retry_cnt   <= '0;
            retries     <= 2'd0;
            pll_rst     <= 1'b1;
            sys_rst_req <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else if (restart) begin
            // restart takes priority over every other transition. While
            // restart is held, PRST stays at its first cycle.
            state       <= S_PRST;
            tmr         <= '0;
            stab        <= '0;
            retry_cnt   <= '0;
            retries     <= 2'd0;
            pll_rst     <= 1'b1;
            sys_rst_req <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            case (state)
                S_PRST: begin
                    if (rst_done) begin
                        state   <= S_WLOCK;
                        tmr     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                // The timer runs from the release of pll_rst until lock
                // qualifies. It is not cleared when lock glitches.
                S_WLOCK, S_STABLE: begin
                    if (qualify) begin
                        state       <= S_RUN;
                        tmr         <= '0;
                        stab        <= '0;
                        retry_cnt   <= '0;
                        retries     <= 2'd0;
                        sys_rst_req <= 1'b0;
                        ready       <= 1'b1;
                    end else if (tmr_expired) begin
                        tmr     <= '0;
                        stab    <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt < RC_W'(MAX_RETRIES)) begin
                            state     <= S_PRST;
                            retry_cnt <= retry_cnt + 1'b1;
                            retries   <= (retries == 2'd3) ? 2'd3 : retries + 2'd1;
                        end else begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end
                    end else if (lk) begin
                        state <= S_STABLE;
                        tmr   <= tmr + 1'b1;
                        stab  <= stab + 1'b1;
                    end else begin
                        state <= S_WLOCK;
                        tmr   <= tmr + 1'b1;
                        stab  <= '0;
                    end
                end

                S_RUN: begin
                    if (!lk) begin
                        state       <= S_PRST;
                        tmr         <= '0;
                        pll_rst     <= 1'b1;
                        sys_rst_req <= 1'b1;
                        ready       <= 1'b0;
                    end
                end

                S_FAIL: begin
                    // Latched until restart or rst.
                end

                default: begin
                    state       <= S_PRST;
                    tmr         <= '0;
                    stab        <= '0;
                    pll_rst     <= 1'b1;
                    sys_rst_req <= 1'b1;
                    ready       <= 1'b0;
                    fail        <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    // A loss also counts when restart arrives in the same cycle. restart
    // only redirects the state; it does not hide the event.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_count <= '0;
        end else if ((state == S_RUN) && !lk && (loss_count != '1)) begin
            loss_count <= loss_count + 1'b1;
        end
    end
`else
    assign loss_count = '0;
`endif

endmodule
